// File: rtl/simon_sequence_engine.sv
// Simon game engine: stores the move sequence, plays it back with per-round speed-up,
// times and checks player presses, and reports score, high score and game events.
module simon_sequence_engine #(
  parameter int N_BUTTONS      = 4,
  parameter int SEL_W          = 2,
  parameter int MAX_LEN        = 32,
  parameter int LEN_W          = 8,
  parameter int ON_CYCLES      = 40000000,
  parameter int STEP_CYCLES    = 2000000,
  parameter int MIN_ON         = 10000000,
  parameter int OFF_CYCLES     = 20000000,
  parameter int TIMEOUT_CYCLES = 300000000,
  parameter int RESULT_CYCLES  = 100000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 replay,
  input  logic [N_BUTTONS-1:0] pressed,
  input  logic [N_BUTTONS-1:0] released,
  input  logic [SEL_W-1:0]     rnd,
  output logic                 light_en,
  output logic [SEL_W-1:0]     light_sel,
  output logic                 success,
  output logic                 failure,
  output logic                 player_turn,
  output logic [LEN_W-1:0]     score,
  output logic [LEN_W-1:0]     high_score,
  output logic                 round_done,
  output logic                 game_over,
  output logic                 game_won
);

  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_ADD_MOVE, S_SHOW_ON, S_SHOW_OFF, S_WAIT_PLAYER,
    S_HOLD, S_CHECK, S_ROUND_WIN, S_GAME_WIN, S_FAIL
  } state_t;

  state_t state_reg, state_next;
  logic [LEN_W-1:0] length_reg, length_next;
  logic [LEN_W-1:0] index_reg, index_next;
  logic [LEN_W-1:0] score_reg, score_next;
  logic [LEN_W-1:0] high_score_reg, high_score_next;
  logic [31:0]      timer_reg, timer_next;
  logic [31:0]      on_t_reg, on_t_next;
  logic [SEL_W-1:0] captured_reg, captured_next;
  logic             round_done_reg, game_over_reg, game_won_reg;

  logic [SEL_W-1:0]  mem [DEPTH];
  logic [SEL_W-1:0]  rd_data_reg;
  logic              mem_we;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [SEL_W-1:0]  new_move;

  logic              press_any;
  logic [SEL_W-1:0]  press_idx;
  logic [N_BUTTONS-1:0] rel_match;
  logic              release_hit;
  logic              timer_done;
  logic [63:0]       on_reduction;
  logic [31:0]       on_t_calc;

  assign timer_done = (timer_reg == 32'd0);
  assign new_move   = SEL_W'(int'(rnd) % N_BUTTONS);
  assign wr_addr    = length_reg[ADDR_W-1:0];
  assign rd_addr    = index_next[ADDR_W-1:0];

  // Light-on time shrinks by STEP per completed round, saturating at MIN_ON.
  assign on_reduction = 64'(length_reg) * 64'(STEP_CYCLES);
  assign on_t_calc = ((ON_CYCLES <= MIN_ON) || (on_reduction >= 64'(ON_CYCLES - MIN_ON)))
                     ? 32'(MIN_ON) : 32'(64'(ON_CYCLES) - on_reduction);

  // Lowest-numbered pressed button wins when several arrive together.
  always_comb begin
    press_any = 1'b0;
    press_idx = '0;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      if (pressed[i]) begin
        press_any = 1'b1;
        press_idx = SEL_W'(i);
      end
    end
  end

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_rel
    assign rel_match[gi] = released[gi] && (captured_reg == SEL_W'(gi));
  end
  assign release_hit = |rel_match;

  // Write-first memory: the move written in ADD_MOVE is visible on the next cycle's read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= new_move;
    if (mem_we && (wr_addr == rd_addr)) rd_data_reg <= new_move;
    else                                rd_data_reg <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      length_reg     <= '0;
      index_reg      <= '0;
      score_reg      <= '0;
      high_score_reg <= '0;
      timer_reg      <= '0;
      on_t_reg       <= '0;
      captured_reg   <= '0;
      round_done_reg <= 1'b0;
      game_over_reg  <= 1'b0;
      game_won_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      length_reg     <= length_next;
      index_reg      <= index_next;
      score_reg      <= score_next;
      high_score_reg <= high_score_next;
      timer_reg      <= timer_next;
      on_t_reg       <= on_t_next;
      captured_reg   <= captured_next;
      round_done_reg <= (state_next == S_ROUND_WIN) && (state_reg != S_ROUND_WIN);
      game_over_reg  <= (state_next == S_FAIL) && (state_reg != S_FAIL);
      game_won_reg   <= (state_next == S_GAME_WIN) && (state_reg != S_GAME_WIN);
    end
  end

  always_comb begin
    state_next      = state_reg;
    length_next     = length_reg;
    index_next      = index_reg;
    score_next      = score_reg;
    high_score_next = high_score_reg;
    timer_next      = timer_reg;
    on_t_next       = on_t_reg;
    captured_next   = captured_reg;
    mem_we          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          length_next = '0;
          score_next  = '0;
          state_next  = S_ADD_MOVE;
        end
      end
      S_ADD_MOVE: begin
        mem_we      = 1'b1;
        length_next = length_reg + LEN_W'(1);
        index_next  = '0;
        on_t_next   = on_t_calc;
        timer_next  = on_t_calc - 32'd1;
        state_next  = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (timer_done) begin
          timer_next = 32'(OFF_CYCLES - 1);
          state_next = S_SHOW_OFF;
        end else begin
          timer_next = timer_reg - 32'd1;
        end
      end
      S_SHOW_OFF: begin
        if (!timer_done) begin
          timer_next = timer_reg - 32'd1;
        end else if (index_reg + LEN_W'(1) == length_reg) begin
          index_next = '0;
          timer_next = 32'(TIMEOUT_CYCLES - 1);
          state_next = S_WAIT_PLAYER;
        end else begin
          index_next = index_reg + LEN_W'(1);
          timer_next = on_t_reg - 32'd1;
          state_next = S_SHOW_ON;
        end
      end
      S_WAIT_PLAYER: begin
        if (press_any) begin
          captured_next = press_idx;
          state_next    = S_HOLD;
        end else if (replay) begin
          index_next = '0;
          timer_next = on_t_reg - 32'd1;
          state_next = S_SHOW_ON;
        end else if (timer_done) begin
          timer_next = 32'(RESULT_CYCLES - 1);
          state_next = S_FAIL;
        end else begin
          timer_next = timer_reg - 32'd1;
        end
      end
      S_HOLD: begin
        if (release_hit) state_next = S_CHECK;
      end
      S_CHECK: begin
        if (captured_reg != rd_data_reg) begin
          timer_next = 32'(RESULT_CYCLES - 1);
          state_next = S_FAIL;
        end else if (index_reg + LEN_W'(1) == length_reg) begin
          score_next = length_reg;
          timer_next = 32'(RESULT_CYCLES - 1);
          state_next = S_ROUND_WIN;
        end else begin
          index_next = index_reg + LEN_W'(1);
          timer_next = 32'(TIMEOUT_CYCLES - 1);
          state_next = S_WAIT_PLAYER;
        end
      end
      S_ROUND_WIN: begin
        if (score_reg > high_score_reg) high_score_next = score_reg;
        if (!timer_done) begin
          timer_next = timer_reg - 32'd1;
        end else if (length_reg == LEN_W'(MAX_LEN)) begin
          timer_next = 32'(RESULT_CYCLES - 1);
          state_next = S_GAME_WIN;
        end else begin
          state_next = S_ADD_MOVE;
        end
      end
      S_GAME_WIN, S_FAIL: begin
        if (timer_done) state_next = S_IDLE;
        else            timer_next = timer_reg - 32'd1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign light_en    = (state_reg == S_SHOW_ON) || (state_reg == S_HOLD);
  assign light_sel   = (state_reg == S_SHOW_ON) ? rd_data_reg :
                       (state_reg == S_HOLD)    ? captured_reg : '0;
  assign success     = (state_reg == S_ROUND_WIN) || (state_reg == S_GAME_WIN);
  assign failure     = (state_reg == S_FAIL);
  assign player_turn = (state_reg == S_WAIT_PLAYER) || (state_reg == S_HOLD);
  assign score       = score_reg;
  assign high_score  = high_score_reg;
  assign round_done  = round_done_reg;
  assign game_over   = game_over_reg;
  assign game_won    = game_won_reg;

endmodule

// File: tb/tb_simon_sequence_engine.sv
// Randomised bench for simon_sequence_engine with a move-list model of the game rules.
module tb_simon_sequence_engine;
  localparam int N_BUTTONS      = 4;
  localparam int SEL_W          = 2;
  localparam int MAX_LEN        = 3;
  localparam int LEN_W          = 8;
  localparam int ON_CYCLES      = 4;
  localparam int STEP_CYCLES    = 1;
  localparam int MIN_ON         = 3;
  localparam int OFF_CYCLES     = 2;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int RESULT_CYCLES  = 3;

  logic clk = 1'b0;
  logic reset, start, replay;
  logic [N_BUTTONS-1:0] pressed, released;
  logic [SEL_W-1:0] rnd;
  logic light_en, success, failure, player_turn, round_done, game_over, game_won;
  logic [SEL_W-1:0] light_sel;
  logic [LEN_W-1:0] score, high_score;

  int checks = 0;
  int passes = 0;
  int model_moves[$];
  int model_score = 0;
  int model_high = 0;

  simon_sequence_engine #(
    .N_BUTTONS(N_BUTTONS), .SEL_W(SEL_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
    .ON_CYCLES(ON_CYCLES), .STEP_CYCLES(STEP_CYCLES), .MIN_ON(MIN_ON),
    .OFF_CYCLES(OFF_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .RESULT_CYCLES(RESULT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .replay(replay),
    .pressed(pressed), .released(released), .rnd(rnd),
    .light_en(light_en), .light_sel(light_sel), .success(success), .failure(failure),
    .player_turn(player_turn), .score(score), .high_score(high_score),
    .round_done(round_done), .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int model_on_t(input int len);
    int v;
    v = ON_CYCLES - (len - 1) * STEP_CYCLES;
    return (v < MIN_ON) ? MIN_ON : v;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; replay = 1'b0;
    pressed = '0; released = '0; rnd = '0;
    tick(); tick();
    checks++;
    if ({light_en, light_sel, success, failure, player_turn, score, high_score,
         round_done, game_over, game_won} !== '0)
      $display("FAIL reset_outputs: got en=%b sel=%0d succ=%b fail=%b turn=%b score=%0d high=%0d required all 0",
               light_en, light_sel, success, failure, player_turn, score, high_score);
    else passes++;
    reset = 1'b0;
    model_score = 0;
    model_high = 0;
    tick();
  endtask

  task automatic start_game(input int r);
    rnd = SEL_W'(r);
    start = 1'b1;
    tick();
    start = 1'b0;
    model_moves.delete();
    model_moves.push_back(r % N_BUTTONS);
    model_score = 0;
    $display("game start first_move=%0d", r % N_BUTTONS);
  endtask

  task automatic check_show();
    int n, on, off, bad, w;
    n = model_moves.size();
    w = 0;
    while (light_en !== 1'b1 && w < 20) begin w++; tick(); end
    for (int k = 0; k < n; k++) begin
      on = 0; bad = 0; off = 0;
      while (light_en === 1'b1 && on < 50) begin
        if (light_sel !== SEL_W'(model_moves[k])) bad++;
        on++;
        tick();
      end
      while (light_en === 1'b0 && player_turn === 1'b0 && off < 50) begin off++; tick(); end
      checks++;
      if (on != model_on_t(n)) $display("FAIL show_on_time: move %0d got %0d cycles required %0d", k, on, model_on_t(n));
      else passes++;
      checks++;
      if (bad != 0) $display("FAIL show_sel: move %0d got %0d wrong-sel cycles required 0 (move %0d)", k, bad, model_moves[k]);
      else passes++;
      checks++;
      if (off != OFF_CYCLES) $display("FAIL show_off_time: move %0d got %0d cycles required %0d", k, off, OFF_CYCLES);
      else passes++;
    end
    checks++;
    if (player_turn !== 1'b1) $display("FAIL show_turn: player_turn got %b required 1", player_turn);
    else passes++;
    $display("shown %0d moves on_t=%0d", n, model_on_t(n));
  endtask

  task automatic press_release(input int btn);
    int d, h;
    d = $urandom_range(0, 4);
    repeat (d) tick();
    pressed = N_BUTTONS'(1 << btn);
    tick();
    pressed = '0;
    checks++;
    if (light_en !== 1'b1 || light_sel !== SEL_W'(btn) || player_turn !== 1'b1)
      $display("FAIL hold_light: got en=%b sel=%0d turn=%b required en=1 sel=%0d turn=1",
               light_en, light_sel, player_turn, btn);
    else passes++;
    h = $urandom_range(0, 3);
    repeat (h) begin
      pressed = N_BUTTONS'($urandom_range(0, 15));
      released = N_BUTTONS'(1 << ((btn + 1) % N_BUTTONS));
      tick();
    end
    pressed = '0;
    released = N_BUTTONS'(1 << btn);
    tick();
    released = '0;
    tick();
  endtask

  task automatic expect_fail();
    int f;
    logic go2;
    go2 = 1'bx;
    checks++;
    if (game_over !== 1'b1 || failure !== 1'b1 || success !== 1'b0)
      $display("FAIL fail_entry: got over=%b failure=%b succ=%b required 1 1 0", game_over, failure, success);
    else passes++;
    f = 0;
    while (failure === 1'b1 && f < 50) begin
      if (f == 1) go2 = game_over;
      f++;
      tick();
    end
    checks++;
    if (f != RESULT_CYCLES || go2 !== 1'b0)
      $display("FAIL fail_length: got %0d cycles pulse2=%b required %0d cycles pulse2=0", f, go2, RESULT_CYCLES);
    else passes++;
    checks++;
    if (score !== LEN_W'(model_score) || high_score !== LEN_W'(model_high) ||
        player_turn !== 1'b0 || light_en !== 1'b0)
      $display("FAIL fail_after: got score=%0d high=%0d turn=%b en=%b required score=%0d high=%0d turn=0 en=0",
               score, high_score, player_turn, light_en, model_score, model_high);
    else passes++;
    $display("game over score=%0d", model_score);
  endtask

  task automatic expect_round_win(input int len);
    int s, r, exp_s;
    logic gw, rd2;
    gw = 1'b0; rd2 = 1'bx;
    checks++;
    if (round_done !== 1'b1 || success !== 1'b1 || score !== LEN_W'(len))
      $display("FAIL round_entry: got done=%b succ=%b score=%0d required 1 1 %0d", round_done, success, score, len);
    else passes++;
    model_score = len;
    if (len > model_high) model_high = len;
    if (len < MAX_LEN) begin
      r = $urandom_range(0, (1 << SEL_W) - 1);
      rnd = SEL_W'(r);
      model_moves.push_back(r % N_BUTTONS);
    end
    s = 0;
    while (success === 1'b1 && s < 50) begin
      if (s == 1) rd2 = round_done;
      if (s == RESULT_CYCLES) gw = game_won;
      s++;
      tick();
    end
    exp_s = (len == MAX_LEN) ? 2 * RESULT_CYCLES : RESULT_CYCLES;
    checks++;
    if (s != exp_s || rd2 !== 1'b0)
      $display("FAIL success_length: got %0d cycles done2=%b required %0d cycles done2=0", s, rd2, exp_s);
    else passes++;
    checks++;
    if (gw !== (len == MAX_LEN)) $display("FAIL game_won_pulse: got %b required %b", gw, len == MAX_LEN);
    else passes++;
    checks++;
    if (high_score !== LEN_W'(model_high) || score !== LEN_W'(model_score))
      $display("FAIL scores: got score=%0d high=%0d required score=%0d high=%0d", score, high_score, model_score, model_high);
    else passes++;
    $display("round %0d won score=%0d high=%0d", len, model_score, model_high);
  endtask

  task automatic answer_round(input int wrong_at, output bit failed);
    int len, btn;
    len = model_moves.size();
    failed = 1'b0;
    for (int k = 0; k < len; k++) begin
      btn = model_moves[k];
      if (k == wrong_at) btn = (btn + 1 + int'($urandom_range(0, N_BUTTONS - 2))) % N_BUTTONS;
      press_release(btn);
      if (k == wrong_at) begin
        expect_fail();
        failed = 1'b1;
        return;
      end
      if (k < len - 1) begin
        checks++;
        if (player_turn !== 1'b1 || success !== 1'b0)
          $display("FAIL next_press: got turn=%b succ=%b required 1 0", player_turn, success);
        else passes++;
      end
    end
    expect_round_win(len);
  endtask

  task automatic test_full_game();
    bit f;
    start_game(2);
    for (int r = 1; r <= MAX_LEN; r++) begin
      check_show();
      answer_round(-1, f);
    end
  endtask

  task automatic test_wrong_button();
    bit f;
    start_game($urandom_range(0, 3));
    check_show();
    answer_round(-1, f);
    check_show();
    answer_round($urandom_range(0, 1), f);
  endtask

  task automatic test_timeout();
    int t;
    start_game($urandom_range(0, 3));
    check_show();
    t = 0;
    while (player_turn === 1'b1 && t < 100) begin
      start = (t == 3);
      t++;
      tick();
    end
    start = 1'b0;
    checks++;
    if (t != TIMEOUT_CYCLES) $display("FAIL timeout: got %0d cycles required %0d", t, TIMEOUT_CYCLES);
    else passes++;
    expect_fail();
  endtask

  task automatic test_simultaneous();
    bit f;
    start_game(1);
    check_show();
    pressed = 4'b0110;
    tick();
    pressed = '0;
    checks++;
    if (light_en !== 1'b1 || light_sel !== 2'd1)
      $display("FAIL simultaneous_capture: got en=%b sel=%0d required en=1 sel=1", light_en, light_sel);
    else passes++;
    released = 4'b0100;
    tick();
    released = '0;
    checks++;
    if (light_en !== 1'b1 || light_sel !== 2'd1 || player_turn !== 1'b1)
      $display("FAIL other_release: got en=%b sel=%0d turn=%b required 1 1 1", light_en, light_sel, player_turn);
    else passes++;
    released = 4'b0010;
    tick();
    released = '0;
    tick();
    expect_round_win(1);
    check_show();
    answer_round(0, f);
  endtask

  task automatic test_replay_and_reset();
    bit f;
    int w;
    start_game($urandom_range(0, 3));
    check_show();
    answer_round(-1, f);
    check_show();
    replay = 1'b1;
    tick();
    replay = 1'b0;
    check_show();
    answer_round(-1, f);
    w = 0;
    while (light_en !== 1'b1 && w < 20) begin w++; tick(); end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({light_en, light_sel, success, failure, player_turn, score, high_score,
         round_done, game_over, game_won} !== '0)
      $display("FAIL midgame_reset: got en=%b sel=%0d turn=%b score=%0d high=%0d required all 0",
               light_en, light_sel, player_turn, score, high_score);
    else passes++;
    reset = 1'b0;
    model_score = 0;
    model_high = 0;
    tick();
  endtask

  task automatic test_random_games();
    bit f;
    int wr;
    for (int g = 0; g < 5; g++) begin
      start_game($urandom_range(0, 3));
      wr = $urandom_range(1, MAX_LEN + 1);
      for (int r = 1; r <= MAX_LEN; r++) begin
        check_show();
        answer_round((r == wr) ? int'($urandom_range(0, r - 1)) : -1, f);
        if (f) break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_game();
    test_wrong_button();
    test_timeout();
    test_simultaneous();
    test_replay_and_reset();
    test_random_games();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
